matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Write side of the matrix buffers read by the multiply-accumulate engine.
- Accepts a serial stream of signed 8-bit elements: first matrix M1, then matrix M2, each row-major, with dimensions sent on each matrix's first beat.
- Stores both matrices and checks that M1 cols equals M2 rows.
- Serves combinational index-based reads to the compute stage until that stage releases the buffers.

Parameters:
- DW, 8, element width (signed).
- DEPTH, 16, entries per matrix buffer (max 4x4).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous active-low reset (sampled on the rising clk edge; 0 = reset).
- in_valid  input  1  stream beat valid.
- in_ready  output  1  loader can accept a beat this cycle.
- in_data  input  DW  signed element.
- in_row_size  input  2  rows-1 of the current matrix; sampled only on a matrix's first beat.
- in_col_size  input  2  cols-1 of the current matrix; sampled only on a matrix's first beat.
- M1_read_idx  input  4  M1 read address (row-major).
- M1_data  output  DW  M1 buffer entry at M1_read_idx, combinational.
- M2_read_idx  input  4  M2 read address.
- M2_data  output  DW  M2 buffer entry at M2_read_idx, combinational.
- M1_row_size, M1_col_size, M2_row_size, M2_col_size  output  2 each  captured dims (count-1).
- loaded  output  1  both matrices valid and dims consistent.
- size_err  output  1  dimension mismatch detected.
- release  input  1  single-cycle pulse from the compute controller: buffers consumed, or abort.

Behaviour:
- Beat accepted when in_valid & in_ready in the same cycle.
- in_ready = 1 in S_M1 and S_M2, 0 in S_READY and S_ERR.
- Reset (rst=0 at the clk edge):
  - state = S_M1, element counter cnt = 0.
  - All size outputs = 0; loaded = 0; size_err = 0.
  - Buffer contents are not cleared; they are don't-care until rewritten.
- S_M1, accepted beat with cnt == 0:
  - Capture in_row_size/in_col_size into M1_row_size/M1_col_size.
  - Compute the last index L1 = (r+1)*(c+1)-1 from the values sampled on that same beat (range 0..15).
- S_M1, every accepted beat: buffer M1[cnt] <= in_data.
  - If cnt == L1: cnt <= 0, go to S_M2.
  - Otherwise cnt <= cnt+1.
- A 1x1 matrix (L1 = 0) completes on its first beat.
- S_M2: identical handling into M2, with last index L2.
- On the M2 last beat:
  - If M1_col_size == M2_row_size (the M2 value is the one sampled in this load, possibly on this same beat when L2 = 0): go to S_READY; loaded is 1 from the next cycle.
  - Otherwise: go to S_ERR; size_err is 1 from the next cycle.
- S_READY: buffers and sizes are frozen; in_valid is ignored. release: go to S_M1, cnt <= 0, loaded <= 0.
- S_ERR: buffers and sizes are frozen; in_valid is ignored. release: go to S_M1, cnt <= 0, size_err <= 0.
- release in S_M1/S_M2 (abort mid-load):
  - Go to S_M1, cnt <= 0.
  - A beat accepted in that same cycle is dropped: no write, no size capture.
  - Partially written data is don't-care.
- Reset has priority over release; release has priority over beat acceptance.
- Read ports:
  - M1_data = M1[M1_read_idx], M2_data = M2[M2_read_idx], zero latency, valid in any state.
  - Contents are guaranteed only while loaded = 1.
  - Index >= (rows*cols) returns stale data; this is not an error.
- Reads and writes never target the same buffer meaningfully in the same cycle, since writes occur only before loaded. No bypass logic.
- Write latency: an element written at edge k is visible on the read port after edge k.

Test Plan:
- 2x3 M1 {1,2,3,4,5,6} then 3x2 M2 {7,8,9,10,11,12}, in_valid held high:
  - in_ready = 1 for 12 cycles.
  - loaded = 1 the cycle after beat 12; sizes M1 = (1,2), M2 = (2,1).
  - M1_read_idx = 5 -> 6; M2_read_idx = 4 -> 11.
- 1x1 M1 {-128}, 1x1 M2 {127}:
  - loaded asserts after 2 beats.
  - M1_data = 8'h80, M2_data = 8'h7F.
- 2x2 M1 then 3x3 M2:
  - size_err = 1, loaded = 0, in_ready = 0 after beat 13.
  - release -> size_err = 0 and in_ready = 1 next cycle.
- 4x4 M1 and 4x4 M2 with in_valid toggled every other cycle:
  - Exactly 32 beats accepted; cnt wraps correctly at 15.
  - M2[15] holds the last value sent.
- Abort and reset cases:
  - release after 3 M2 beats -> state S_M1, cnt = 0; a fresh 2x2/2x2 load then succeeds.
  - rst = 0 during S_READY -> loaded = 0 and in_ready = 1 next cycle.
- Extra beats in S_READY: in_valid = 1 with new data for 5 cycles -> no beat accepted, M1/M2 contents unchanged.

Source files
------------

// File: rtl/matrix_loader.sv
// Write side of the MAC engine's matrix buffers: captures a serial stream of
// M1 then M2 (row-major), validates M1 cols == M2 rows, and serves reads.
module matrix_loader #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic [1:0]           in_row_size,
  input  logic [1:0]           in_col_size,
  input  logic [3:0]           M1_read_idx,
  output logic signed [DW-1:0] M1_data,
  input  logic [3:0]           M2_read_idx,
  output logic signed [DW-1:0] M2_data,
  output logic [1:0]           M1_row_size,
  output logic [1:0]           M1_col_size,
  output logic [1:0]           M2_row_size,
  output logic [1:0]           M2_col_size,
  output logic                 loaded,
  output logic                 size_err,
  // "release" is a reserved word, hence the prefixed name.
  input  logic                 i_release
);

  typedef enum logic [1:0] {S_M1, S_M2, S_READY, S_ERR} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_last;
  logic [1:0]          r_m1_rows, r_m1_cols, r_m2_rows, r_m2_cols;
  logic signed [DW-1:0] r_m1 [DEPTH];
  logic signed [DW-1:0] r_m2 [DEPTH];

  logic       w_accept;
  logic       w_first;
  logic [4:0] w_prod;
  logic [3:0] w_beat_last;
  logic [3:0] w_cur_last;
  logic       w_hit;
  logic [1:0] w_m2_rows;
  logic       w_match;

  assign in_ready    = (r_state == S_M1) || (r_state == S_M2);
  assign w_accept    = in_valid && in_ready && !i_release;
  assign w_first     = (r_cnt == 4'd0);
  assign w_prod      = (5'(in_row_size) + 5'd1) * (5'(in_col_size) + 5'd1);
  assign w_beat_last = 4'(w_prod - 5'd1);
  // On a matrix's first beat the last index comes straight from the inputs.
  assign w_cur_last  = w_first ? w_beat_last : r_last;
  assign w_hit       = (r_cnt == w_cur_last);
  assign w_m2_rows   = w_first ? in_row_size : r_m2_rows;
  assign w_match     = (r_m1_cols == w_m2_rows);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_M1: begin
        if (!i_release && w_accept && w_hit) w_next_state = S_M2;
      end
      S_M2: begin
        if (i_release) w_next_state = S_M1;
        else if (w_accept && w_hit) w_next_state = w_match ? S_READY : S_ERR;
      end
      S_READY, S_ERR: begin
        if (i_release) w_next_state = S_M1;
      end
      default: w_next_state = S_M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_M1;
      r_cnt     <= '0;
      r_last    <= '0;
      r_m1_rows <= '0;
      r_m1_cols <= '0;
      r_m2_rows <= '0;
      r_m2_cols <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_release) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_hit ? 4'd0 : r_cnt + 4'd1;
        if (w_first) begin
          r_last <= w_beat_last;
          if (r_state == S_M1) begin
            r_m1_rows <= in_row_size;
            r_m1_cols <= in_col_size;
          end else begin
            r_m2_rows <= in_row_size;
            r_m2_cols <= in_col_size;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      if (r_state == S_M1) r_m1[r_cnt] <= in_data;
      else                 r_m2[r_cnt] <= in_data;
    end
  end

  assign M1_data     = r_m1[M1_read_idx];
  assign M2_data     = r_m2[M2_read_idx];
  assign M1_row_size = r_m1_rows;
  assign M1_col_size = r_m1_cols;
  assign M2_row_size = r_m2_rows;
  assign M2_col_size = r_m2_cols;
  assign loaded      = (r_state == S_READY);
  assign size_err    = (r_state == S_ERR);

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: load, boundary sizes, mismatch, abort,
// reset and ignored-beat scenarios with hand-computed expectations.
module tb_matrix_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_row_size, in_col_size;
  logic [3:0] M1_read_idx, M2_read_idx;
  logic [7:0] M1_data, M2_data;
  logic [1:0] M1_row_size, M1_col_size, M2_row_size, M2_col_size;
  logic       loaded, size_err;
  logic       rel;

  int checks = 0;
  int errors = 0;
  int accepted;

  matrix_loader #(.DW(8), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_row_size (in_row_size),
    .in_col_size (in_col_size),
    .M1_read_idx (M1_read_idx),
    .M1_data     (M1_data),
    .M2_read_idx (M2_read_idx),
    .M2_data     (M2_data),
    .M1_row_size (M1_row_size),
    .M1_col_size (M1_col_size),
    .M2_row_size (M2_row_size),
    .M2_col_size (M2_col_size),
    .loaded      (loaded),
    .size_err    (size_err),
    .i_release   (rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat with in_valid high and confirm the loader takes it.
  task automatic beat(input logic [7:0] d, input logic [1:0] r, input logic [1:0] c);
    in_valid    = 1'b1;
    in_data     = d;
    in_row_size = r;
    in_col_size = c;
    chk("beat_ready", in_ready, 1);
    tick();
  endtask

  task automatic rd(input string tag, input logic [3:0] i1, input logic [3:0] i2,
                    input logic [7:0] e1, input logic [7:0] e2);
    M1_read_idx = i1;
    M2_read_idx = i2;
    #1;
    chk({tag, "_m1"}, M1_data, e1);
    chk({tag, "_m2"}, M2_data, e2);
  endtask

  task automatic pulse_release();
    rel = 1'b1;
    tick();
    rel = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_row_size = '0; in_col_size = '0;
    M1_read_idx = '0; M2_read_idx = '0; rel = 1'b0;
    tick(); tick();
    chk("rst_loaded", loaded, 0);
    chk("rst_err", size_err, 0);
    chk("rst_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // 2x3 M1 then 3x2 M2, in_valid held high
    for (int k = 1; k <= 6; k++) begin
      beat(8'(k), 2'd1, 2'd2);
      if (k == 1) chk("m1_loaded_early", loaded, 0);
    end
    for (int k = 7; k <= 12; k++) beat(8'(k), 2'd2, 2'd1);
    in_valid = 1'b0;
    chk("t1_loaded", loaded, 1);
    chk("t1_err", size_err, 0);
    chk("t1_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 8'b01_10_10_01);
    rd("t1_a", 4'd5, 4'd4, 8'd6, 8'd11);
    rd("t1_b", 4'd0, 4'd0, 8'd1, 8'd7);

    // extra beats while loaded are ignored
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h55; in_row_size = 2'd3; in_col_size = 2'd3;
      chk("rdy_blocked", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("rdy_still_loaded", loaded, 1);
    chk("rdy_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 8'b01_10_10_01);
    rd("rdy_c", 4'd0, 4'd5, 8'd1, 8'd12);
    rd("rdy_d", 4'd5, 4'd0, 8'd6, 8'd7);
    pulse_release();
    chk("rel_loaded", loaded, 0);
    chk("rel_ready", in_ready, 1);

    // 1x1 boundary, extreme signed values
    beat(8'h80, 2'd0, 2'd0);
    chk("one_mid_loaded", loaded, 0);
    beat(8'h7F, 2'd0, 2'd0);
    in_valid = 1'b0;
    chk("one_loaded", loaded, 1);
    rd("one", 4'd0, 4'd0, 8'h80, 8'h7F);
    pulse_release();

    // 2x2 then 3x3: dimension mismatch
    for (int k = 0; k < 4; k++) beat(8'(k), 2'd1, 2'd1);
    for (int k = 0; k < 9; k++) beat(8'(k), 2'd2, 2'd2);
    in_valid = 1'b0;
    chk("mm_err", size_err, 1);
    chk("mm_loaded", loaded, 0);
    chk("mm_ready", in_ready, 0);
    pulse_release();
    chk("mm_rel_err", size_err, 0);
    chk("mm_rel_ready", in_ready, 1);

    // 4x4 and 4x4 with in_valid every other cycle
    accepted = 0;
    in_row_size = 2'd3; in_col_size = 2'd3;
    for (int i = 0; i < 80; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (accepted < 16) ? 8'(accepted + 16) : 8'(accepted - 16 + 100);
      if (in_valid && in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    chk("big_beats", accepted, 32);
    chk("big_loaded", loaded, 1);
    chk("big_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 8'hFF);
    rd("big_last", 4'd15, 4'd15, 8'd31, 8'd115);
    rd("big_first", 4'd0, 4'd0, 8'd16, 8'd100);
    pulse_release();

    // abort after 3 M2 beats; the beat offered alongside release is dropped
    for (int k = 0; k < 4; k++) beat(8'(k + 1), 2'd1, 2'd1);
    for (int k = 0; k < 3; k++) beat(8'(k + 40), 2'd1, 2'd1);
    in_valid = 1'b1; in_data = 8'd99; in_row_size = 2'd3; in_col_size = 2'd3;
    pulse_release();
    in_valid = 1'b0;
    chk("abort_ready", in_ready, 1);
    chk("abort_loaded", loaded, 0);
    for (int k = 0; k < 4; k++) beat(8'(k + 10), 2'd1, 2'd1);
    for (int k = 0; k < 3; k++) beat(8'(k + 20), 2'd1, 2'd1);
    chk("fresh_not_yet", loaded, 0);
    beat(8'd23, 2'd1, 2'd1);
    in_valid = 1'b0;
    chk("fresh_loaded", loaded, 1);
    chk("fresh_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 8'b01_01_01_01);
    rd("fresh", 4'd3, 4'd3, 8'd13, 8'd23);
    rd("fresh0", 4'd0, 4'd0, 8'd10, 8'd20);

    // reset while loaded
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rr_loaded", loaded, 0);
    chk("rr_ready", in_ready, 1);
    chk("rr_sizes", {M1_row_size, M1_col_size, M2_row_size, M2_col_size}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
